arb_l1_rr: RTL



---
 rtl/arb_l1_rr.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/arb_l1_rr.sv
// arb_l1_rr: two-master (instruction m0, data m1) to one-slave MemSplit32 arbiter with in-order read-response routing.
// Optional ARB_L1_FIXED_PRIO_EN: m1 always wins contention and the round-robin pointer is removed.
package arb_l1_rr_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } ms32_req_t;
endpackage

module arb_l1_rr
  import arb_l1_rr_pkg::*;
#(
  parameter int unsigned RD_FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // m0: instruction master
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [BE_W-1:0]   m0_be_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_c,
  output logic              m0_resp_c,
  output logic [DATA_W-1:0] m0_rdata_c,
  // m1: data master
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [BE_W-1:0]   m1_be_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_c,
  output logic              m1_resp_c,
  output logic [DATA_W-1:0] m1_rdata_c,
  // s: merged stream towards the L2 arbiter
  output logic              s_req_c,
  output logic              s_we_c,
  output logic [ADDR_W-1:0] s_addr_c,
  output logic [BE_W-1:0]   s_be_c,
  output logic [DATA_W-1:0] s_wdata_c,
  input  logic              s_ack_i,
  input  logic              s_resp_i,
  input  logic [DATA_W-1:0] s_rdata_i
);

  localparam int unsigned PTR_W = $clog2(RD_FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic                     lock_q, lock_d;
  logic                     lock_id_q, lock_id_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [RD_FIFO_DEPTH-1:0] fifo_q, fifo_d;

  ms32_req_t m0_pl, m1_pl, s_pl;
  logic      rd_full;
  logic      m0_elig, m1_elig;
  logic      both_pick;
  logic      gnt_valid, gnt_id;
  logic      accept, push, pop, head_id;

`ifdef ARB_L1_FIXED_PRIO_EN
  assign both_pick = 1'b1;
`else
  logic rr_prio_q, rr_prio_d;
  assign both_pick = rr_prio_q;
`endif

  // Reads are only eligible while the registered outstanding count has room.
  always_comb begin
    m0_pl   = '{we: m0_we_i, addr: m0_addr_i, be: m0_be_i, wdata: m0_wdata_i};
    m1_pl   = '{we: m1_we_i, addr: m1_addr_i, be: m1_be_i, wdata: m1_wdata_i};
    rd_full = (count_q == CNT_W'(RD_FIFO_DEPTH));
    m0_elig = m0_req_i && (m0_we_i || !rd_full);
    m1_elig = m1_req_i && (m1_we_i || !rd_full);
  end

  // Grant selection: a held (locked) request beats contention resolution.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (lock_q) begin
      gnt_id    = lock_id_q;
      gnt_valid = lock_id_q ? m1_req_i : m0_req_i;
    end else if (m0_elig && m1_elig) begin
      gnt_valid = 1'b1;
      gnt_id    = both_pick;
    end else if (m0_elig) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b0;
    end else if (m1_elig) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b1;
    end
    if (rst_i) begin
      gnt_valid = 1'b0;
    end
  end

  always_comb begin
    accept  = gnt_valid && s_ack_i;
    push    = accept && !s_pl.we;
    pop     = s_resp_i && (count_q != '0) && !rst_i;
    head_id = fifo_q[rd_ptr_q];
  end

  // Request mux and response demux.
  always_comb begin
    s_pl = '0;
    if (gnt_valid) begin
      s_pl = gnt_id ? m1_pl : m0_pl;
    end
    s_req_c    = gnt_valid;
    s_we_c     = s_pl.we;
    s_addr_c   = s_pl.addr;
    s_be_c     = s_pl.be;
    s_wdata_c  = s_pl.wdata;
    m0_ack_c   = accept && !gnt_id;
    m1_ack_c   = accept && gnt_id;
    m0_resp_c  = pop && !head_id;
    m1_resp_c  = pop && head_id;
    m0_rdata_c = (pop && !head_id) ? s_rdata_i : '0;
    m1_rdata_c = (pop && head_id) ? s_rdata_i : '0;
  end

  // Lock, priority and read-ID FIFO next state.
  always_comb begin
    lock_d    = gnt_valid && !s_ack_i;
    lock_id_d = (gnt_valid && !s_ack_i) ? gnt_id : lock_id_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = gnt_id;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

`ifndef ARB_L1_FIXED_PRIO_EN
  always_comb begin
    rr_prio_d = rr_prio_q;
    if (accept) begin
      rr_prio_d = !gnt_id;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_prio_q <= 1'b0;
    end else begin
      rr_prio_q <= rr_prio_d;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fifo_q    <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fifo_q    <= fifo_d;
    end
  end

  // The full check on eligibility must make an overflowing push impossible.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && rd_full));

endmodule
